regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file for the MIPS datapath: NR combinational read ports and two synchronous write ports.
- Adds a per-register busy scoreboard for pending long-latency results.
- Adds a sequential clear engine that zeroes one entry per cycle after reset.
- Replaces the fixed 32x32, two-read, one-write file in the decode stage; supports dual-issue writeback.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth is DEPTH = 2**AW entries.
- NR, 2, number of read ports (1..8).
- ZERO_R0, 1: if 1, entry 0 always reads 0 and ignores writes; if 0, entry 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  reset, synchronous, active-high.
- rd_addr  in  NR*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NR*DW  packed read data, combinational.
- rd_busy  out  NR  busy bit of the entry addressed by each read port, combinational.
- w0_en  in  1  write port 0 enable.
- w0_addr  in  AW  write port 0 address.
- w0_data  in  DW  write port 0 data.
- w1_en  in  1  write port 1 enable.
- w1_addr  in  AW  write port 1 address.
- w1_data  in  DW  write port 1 data.
- bs_en  in  1  busy-set enable (issue of a pending producer).
- bs_addr  in  AW  entry to mark busy.
- init_done  out  1  high once the clear sequence has completed.

Behaviour:
- Reset is synchronous, active-high: clk is the only clock, and clr is sampled on the rising edge of clk.
- Clear engine FSM:
  - States CLEARING and READY.
  - clr=1 at an edge: next state CLEARING, clear counter cnt=0, all busy bits 0, init_done=0.
  - CLEARING: each edge writes 0 to entry cnt and increments cnt. After entry DEPTH-1 is written, next state is READY. With clr released, this takes exactly DEPTH cycles.
  - READY: init_done=1. The FSM stays in READY until clr.
  - clr asserted mid-sequence restarts at cnt=0.
  - Reset values: init_done=0, rd_busy=0, rd_data=0 on all ports.
- During CLEARING:
  - w0/w1 writes and bs_en are ignored.
  - rd_data returns 0 and rd_busy returns 0 on every port.
- Reads in READY:
  - rd_data[i] = entry rd_addr[i]. No read latency.
  - If ZERO_R0=1 and rd_addr[i]=0, rd_data[i]=0 and rd_busy[i]=0.
- Writes in READY:
  - On the edge where wX_en=1, entry wX_addr is updated.
  - If both ports address the same entry in the same cycle, port 1 data wins.
  - Writes to entry 0 are dropped when ZERO_R0=1.
- Scoreboard:
  - bs_en=1 sets busy[bs_addr] at the edge.
  - A write on either port clears busy[waddr] at the same edge.
  - Set and clear of the same entry in the same cycle: set wins, and the data write still happens.
  - bs_addr=0 is ignored when ZERO_R0=1.
- Widths: no arithmetic. Addresses always fall in 0..DEPTH-1, so there is no out-of-range case.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined (READY state only): a read port whose address matches an enabled write address in the same cycle returns that write data combinationally. Port 1 has priority over port 0. rd_busy for that port reads 0 unless bs_en targets the same entry in that cycle.
- Not defined: same-cycle reads return the pre-write array value. The new value is visible after the edge.

Test Plan:
- Reset clear: DEPTH=32 with clr=1 for 1 cycle, then 0 -> init_done low for exactly 32 cycles, then high; every entry reads 0x00000000; a write attempted during clearing is ignored.
- Dual write collision: READY, w0 (addr 5, 0x11111111) and w1 (addr 5, 0x22222222) in the same cycle -> next cycle reads 0x22222222; a separate write of 0xDEADBEEF to addr 0 reads back 0.
- Scoreboard: bs_en addr 7 -> rd_busy=1 next cycle; w0 write addr 7 with 0x3C -> busy cleared and data 0x3C. Then bs_en and w1 to addr 7 in the same cycle -> busy stays 1 and data is updated.
- Reset mid-clear: assert clr at cnt=12 -> init_done takes another full 32 cycles; busy bits cleared.
- Bypass: with REGFILE_BYPASS_EN, read addr 9 while w0 writes 0x0001 to addr 9 -> same-cycle rd_data=0x0001. Without the macro -> old value that cycle, 0x0001 the next cycle.
- Multi-port: NR=4 with addresses 1,2,10,0 after writing 0x1, 0x1, 0x3C -> rd_data = 0x1, 0x1, 0x3C, 0x0 simultaneously.

Source files
------------

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- multi-port register file for the MIPS decode stage
//
// Purpose:
//   DEPTH = 2**AW entries of DW bits, NR combinational read ports and two
//   synchronous write ports (dual-issue writeback). A per-entry busy
//   scoreboard tracks pending long-latency producers. After clr, a clear
//   engine zeroes one entry per cycle and raises init_done when finished.
//
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high reset (restarts the clear engine)
//   rd_addr    NR packed read addresses, port i at [i*AW +: AW]
//   rd_data    NR packed read data (combinational), port i at [i*DW +: DW]
//   rd_busy    busy bit of the entry addressed by each read port
//   w0_*       write port 0 (enable / address / data)
//   w1_*       write port 1 (enable / address / data), wins on collision
//   bs_en      mark entry bs_addr busy
//   bs_addr    entry to mark busy
//   init_done  high once the clear sequence has completed
//
// Configuration:
//   REGFILE_BYPASS_EN  when defined, a read that matches an enabled write
//                      in the same cycle returns the write data directly.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NR      = 2,
    parameter int ZERO_R0 = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    output logic [NR-1:0]    rd_busy,
    input  logic             w0_en,
    input  logic [AW-1:0]    w0_addr,
    input  logic [DW-1:0]    w0_data,
    input  logic             w1_en,
    input  logic [AW-1:0]    w1_addr,
    input  logic [DW-1:0]    w1_data,
    input  logic             bs_en,
    input  logic [AW-1:0]    bs_addr,
    output logic             init_done
);

    localparam int DEPTH     = 2 ** AW;
    localparam bit HARD_ZERO = (ZERO_R0 != 0);

    typedef enum logic {
        CLEARING,
        READY
    } state_t;

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;

    // Entry 0 is hard-wired to zero when HARD_ZERO, so requests aimed at it
    // are dropped before they reach the array or the scoreboard.
    logic w0Ok;
    logic w1Ok;
    logic bsOk;

    assign w0Ok = w0_en && !(HARD_ZERO && (w0_addr == '0));
    assign w1Ok = w1_en && !(HARD_ZERO && (w1_addr == '0));
    assign bsOk = bs_en && !(HARD_ZERO && (bs_addr == '0));

    // Clear engine: walks cnt from 0 to DEPTH-1, then parks in READY.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= CLEARING;
            cnt       <= '0;
            init_done <= 1'b0;
        end else if (state == CLEARING) begin
            cnt <= cnt + AW'(1);
            if (cnt == AW'(DEPTH - 1)) begin
                state     <= READY;
                init_done <= 1'b1;
            end
        end
    end

    // NOTE: the array has no reset branch; the clear engine zeroes it one
    // entry per cycle, so it can map onto plain RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (state == CLEARING) begin
                mem[cnt] <= '0;
            end else begin
                if (w0Ok) mem[w0_addr] <= w0_data;
                // Port 1 is assigned last so it wins an address collision.
                if (w1Ok) mem[w1_addr] <= w1_data;
            end
        end
    end

    // NOTE: combinational next-state uses blocking assignments with a
    // default first (no latch); the register below uses non-blocking only.
    always_comb begin
        busyNext = busy;
        if (w0Ok) busyNext[w0_addr] = 1'b0;
        if (w1Ok) busyNext[w1_addr] = 1'b0;
        // Set is applied after the clears so a same-cycle set wins.
        if (bsOk) busyNext[bs_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            busy <= '0;
        end else if (state == READY) begin
            busy <= busyNext;
        end
    end

    // Read ports: purely combinational, forced to zero until READY.
    logic [AW-1:0] rAddr;
    logic [DW-1:0] rVal;
    logic          rBsy;

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rAddr   = '0;
        rVal    = '0;
        rBsy    = 1'b0;
        for (int i = 0; i < NR; i++) begin
            rAddr = rd_addr[i*AW +: AW];
            rVal  = mem[rAddr];
            rBsy  = busy[rAddr];
`ifdef REGFILE_BYPASS_EN
            // Forward same-cycle write data; port 1 has priority. The entry
            // is about to be written, so it is only busy if re-marked now.
            if (w1_en && (w1_addr == rAddr)) begin
                rVal = w1_data;
                rBsy = bsOk && (bs_addr == rAddr);
            end else if (w0_en && (w0_addr == rAddr)) begin
                rVal = w0_data;
                rBsy = bsOk && (bs_addr == rAddr);
            end
`endif
            if (HARD_ZERO && (rAddr == '0)) begin
                rVal = '0;
                rBsy = 1'b0;
            end
            if (state == READY) begin
                rd_data[i*DW +: DW] = rVal;
                rd_busy[i]          = rBsy;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp (NR=4, 32x32, ZERO_R0=1)
//
// Directed vectors carry hand-derived expected read data/busy; a small
// reference model supplies expectations for a random phase. Expected values
// are queued when a vector is driven and popped when outputs are sampled on
// the falling edge. Clear-sequence corner cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 4;
    localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clr;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic             w0_en;
    logic [AW-1:0]    w0_addr;
    logic [DW-1:0]    w0_data;
    logic             w1_en;
    logic [AW-1:0]    w1_addr;
    logic [DW-1:0]    w1_data;
    logic             bs_en;
    logic [AW-1:0]    bs_addr;
    logic             init_done;

    always #5 clk = ~clk;

    regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .ZERO_R0(1)) dut (
        .clk       (clk),
        .clr       (clr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .w0_en     (w0_en),
        .w0_addr   (w0_addr),
        .w0_data   (w0_data),
        .w1_en     (w1_en),
        .w1_addr   (w1_addr),
        .w1_data   (w1_data),
        .bs_en     (bs_en),
        .bs_addr   (bs_addr),
        .init_done (init_done)
    );

    typedef struct packed {
        logic             w0e;
        logic [AW-1:0]    w0a;
        logic [DW-1:0]    w0d;
        logic             w1e;
        logic [AW-1:0]    w1a;
        logic [DW-1:0]    w1d;
        logic             bse;
        logic [AW-1:0]    bsa;
        logic [NR*AW-1:0] ra;
        logic [NR*DW-1:0] ed;
        logic [NR-1:0]    eb;
    } vec_t;

    typedef struct packed {
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    busy;
    } exp_t;

    exp_t             sbq[$];
    vec_t             vecs[12];
    logic [DW-1:0]    mMem [DEPTH];
    logic [DEPTH-1:0] mBusy;
    int               checks = 0;
    int               errors = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic w0e, input int w0a, input logic [DW-1:0] w0d,
        input logic w1e, input int w1a, input logic [DW-1:0] w1d,
        input logic bse, input int bsa,
        input int a0, input int a1, input int a2, input int a3,
        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
        input logic [DW-1:0] d2, input logic [DW-1:0] d3,
        input logic b0, input logic b1, input logic b2, input logic b3);
        vec_t v;
        v.w0e = w0e; v.w0a = AW'(w0a); v.w0d = w0d;
        v.w1e = w1e; v.w1a = AW'(w1a); v.w1d = w1d;
        v.bse = bse; v.bsa = AW'(bsa);
        v.ra  = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
        v.ed  = {d3, d2, d1, d0};
        v.eb  = {b3, b2, b1, b0};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        w0_en = v.w0e; w0_addr = v.w0a; w0_data = v.w0d;
        w1_en = v.w1e; w1_addr = v.w1a; w1_data = v.w1d;
        bs_en = v.bse; bs_addr = v.bsa;
        rd_addr = v.ra;
    endtask

    task automatic idle();
        w0_en = 1'b0; w0_addr = '0; w0_data = '0;
        w1_en = 1'b0; w1_addr = '0; w1_data = '0;
        bs_en = 1'b0; bs_addr = '0;
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
        mBusy = '0;
    endtask

    // Architectural state update for one READY edge.
    task automatic modelUpdate(input vec_t v);
        if (v.w0e && v.w0a != '0) begin mMem[v.w0a] = v.w0d; mBusy[v.w0a] = 1'b0; end
        if (v.w1e && v.w1a != '0) begin mMem[v.w1a] = v.w1d; mBusy[v.w1a] = 1'b0; end
        if (v.bse && v.bsa != '0) mBusy[v.bsa] = 1'b1;
    endtask

    function automatic exp_t predict(input vec_t v);
        exp_t          e;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          b;
        e = '0;
        for (int i = 0; i < NR; i++) begin
            a = v.ra[i*AW +: AW];
            d = mMem[a];
            b = mBusy[a];
`ifdef REGFILE_BYPASS_EN
            if (v.w1e && v.w1a == a) begin
                d = v.w1d; b = v.bse && v.bsa == a;
            end else if (v.w0e && v.w0a == a) begin
                d = v.w0d; b = v.bse && v.bsa == a;
            end
`endif
            if (a == '0) begin d = '0; b = 1'b0; end
            e.data[i*DW +: DW] = d;
            e.busy[i]          = b;
        end
        return e;
    endfunction

    task automatic scoreCheck(input string name);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got data %h busy %h", name, rd_data, rd_busy);
        end else begin
            e = sbq.pop_front();
            check({name, " data"}, rd_data, e.data);
            check({name, " busy"}, rd_busy, e.busy);
        end
    endtask

    // One READY cycle: drive at posedge+1, compare at negedge, then the edge.
    task automatic stepExp(input vec_t v, input exp_t e, input string name);
        drive(v);
        sbq.push_back(e);
        @(negedge clk);
        scoreCheck(name);
        modelUpdate(v);
        @(posedge clk); #1;
    endtask

    task automatic waitClear(input string name);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 100) begin
            @(negedge clk);
            check({name, " rd"}, {rd_busy, rd_data}, '0);
            @(posedge clk); #1;
            n++;
        end
        check({name, " len"}, n, 32);
    endtask

    task automatic sweep(input string name);
        idle();
        for (int g = 0; g < DEPTH / NR; g++) begin
            rd_addr = {AW'(4*g+3), AW'(4*g+2), AW'(4*g+1), AW'(4*g)};
            @(negedge clk);
            check($sformatf("%s grp%0d", name, g), {init_done, rd_busy, rd_data}, {1'b1, 4'b0, 128'b0});
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        exp_t e;

        vecs[0]  = mk(1, 5, 32'h11111111, 1, 5, 32'h22222222, 0, 0, 5, 0, 0, 0,
                      BYP ? 32'h22222222 : 32'h0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0, 0, 0,
                      32'h22222222, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 7, 32'h3C, 0, 0, 0, 0, 0, 7, 0, 0, 0,
                      BYP ? 32'h3C : 32'h0, 0, 0, 0, !BYP, 0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 1, 7, 32'h55, 1, 7, 7, 0, 0, 0,
                      BYP ? 32'h55 : 32'h3C, 0, 0, 0, BYP, 0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 7, 5, 0, 9,
                      32'h55, 32'h22222222, 0, 0, 1, 0, 0, 0);
        vecs[6]  = mk(1, 9, 32'h1, 0, 0, 0, 0, 0, 9, 0, 7, 5,
                      BYP ? 32'h1 : 32'h0, 0, 32'h55, 32'h22222222, 0, 0, 1, 0);
        vecs[7]  = mk(1, 1, 32'h1, 1, 2, 32'h1, 0, 0, 9, 1, 2, 0,
                      32'h1, BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0, 0, 0, 0, 0, 0);
        vecs[8]  = mk(1, 10, 32'h3C, 0, 0, 0, 0, 0, 1, 2, 10, 0,
                      32'h1, 32'h1, BYP ? 32'h3C : 32'h0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 10, 0,
                      32'h1, 32'h1, 32'h3C, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0, 0, 0,
                      BYP ? 32'h77 : 32'h55, 0, 0, 0, !BYP, 0, 0, 0);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 9, 10, 5,
                      32'h77, 32'h1, 32'h3C, 32'h22222222, 0, 0, 0, 0);

        // Reset and first clear; writes and busy-set held active throughout.
        clr = 1'b1;
        idle();
        rd_addr = {AW'(5), AW'(7), AW'(9), AW'(31)};
        @(posedge clk); #1;
        check("reset init_done", init_done, 1'b0);
        check("reset rd_data", rd_data, '0);
        check("reset rd_busy", rd_busy, '0);
        clr = 1'b0;
        w0_en = 1'b1; w0_addr = AW'(3); w0_data = 32'hAAAA5555;
        w1_en = 1'b1; w1_addr = AW'(6); w1_data = 32'h5A5A5A5A;
        bs_en = 1'b1; bs_addr = AW'(4);
        waitClear("clear1");
        idle();
        modelReset();
        sweep("sweep1");

        // Directed vectors.
        for (int r = 0; r < 12; r++) begin
            e.data = vecs[r].ed;
            e.busy = vecs[r].eb;
            stepExp(vecs[r], e, $sformatf("vec%0d", r));
        end

        // Random traffic against the reference model.
        for (int k = 0; k < 60; k++) begin
            v = '0;
            v.w0e = 1'($urandom_range(0, 1));
            v.w0a = AW'($urandom_range(0, 15));
            v.w0d = $urandom;
            v.w1e = 1'($urandom_range(0, 1));
            v.w1a = AW'($urandom_range(0, 15));
            v.w1d = $urandom;
            v.bse = 1'($urandom_range(0, 1));
            v.bsa = AW'($urandom_range(0, 15));
            for (int i = 0; i < NR; i++) v.ra[i*AW +: AW] = AW'($urandom_range(0, 15));
            stepExp(v, predict(v), $sformatf("rand%0d", k));
        end

        // Mid-clear restart: leave data and busy behind, restart at cnt=12.
        v = mk(1, 9, 32'h1234, 0, 0, 0, 1, 12, 12, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepExp(v, predict(v), "pre busy set");
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepExp(v, predict(v), "pre busy read");
        idle();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("midclr init_done", init_done, 1'b0);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        waitClear("clear2");
        modelReset();
        sweep("sweep2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
